calcn_engine: RTL and testbench

CALCN_ENGINE -- requirements
Module: calcn_engine

---
 rtl/calcn_engine_if.sv | 24 ++
 rtl/calcn_engine.sv | 187 ++++++++++++++++++
 tb/tb_calcn_engine.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calcn_engine_if.sv
// rtl/calcn_engine_if.sv - request/response bundle for calcn_engine
interface calcn_engine_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2
);
  logic [NUM_PORTS*4-1:0]      req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS*2-1:0]      out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS*TAG_W-1:0]  out_tag;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  req_ready, out_resp, out_data, out_tag
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output req_ready, out_resp, out_data, out_tag
  );
endinterface

// File: rtl/calcn_engine.sv
// rtl/calcn_engine.sv - per-port request FIFOs feeding one round-robin shared ALU
module calcn_engine #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input logic          c_clk,
  input logic          reset,
  calcn_engine_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  // Request FIFO storage, one row per port
  logic [3:0]        mem_cmd [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0] mem_a   [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0] mem_b   [NUM_PORTS][DEPTH];
  logic [TAG_W-1:0]  mem_tag [NUM_PORTS][DEPTH];
  logic [AW-1:0]     wr_ptr  [NUM_PORTS];
  logic [AW-1:0]     rd_ptr  [NUM_PORTS];
  logic [CW-1:0]     count   [NUM_PORTS];

  // First-cycle capture; operand2 arrives on the following cycle
  logic [NUM_PORTS-1:0] cap_busy;
  logic [3:0]           cap_cmd [NUM_PORTS];
  logic [DATA_W-1:0]    cap_a   [NUM_PORTS];
  logic [TAG_W-1:0]     cap_tag [NUM_PORTS];

  logic [NUM_PORTS-1:0] push, pop, nonempty, ready_int;
  logic [PW-1:0]        prio, gnt_port;
  logic                 gnt_valid;

  // ALU operand stage and result
  logic              s1_valid;
  logic [PW-1:0]     s1_port;
  logic [3:0]        s1_cmd;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [TAG_W-1:0]  s1_tag;
  logic [1:0]        res_resp;
  logic [DATA_W-1:0] res_data;
  logic [DATA_W:0]   sum;

  // Per-port handshake: a pending capture reserves a slot, a same-cycle pop earns no credit
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p]      = cap_busy[p];
      pop[p]       = gnt_valid && (gnt_port == PW'(p));
      nonempty[p]  = (count[p] != '0);
      ready_int[p] = reset && ((int'(count[p]) + int'(cap_busy[p])) < DEPTH);
    end
  end

  assign bus.req_ready = ready_int;

  // Round-robin pick of the first non-empty FIFO at or after the priority pointer
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_port  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(prio) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_valid && nonempty[idx]) begin
        gnt_valid = 1'b1;
        gnt_port  = PW'(idx);
      end
    end
  end

  // Capture command, tag and operand1; the next cycle completes the request
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cap_busy <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cap_cmd[p] <= '0;
        cap_a[p]   <= '0;
        cap_tag[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cap_busy[p]) begin
          cap_busy[p] <= 1'b0;
        end else if (ready_int[p] && (bus.req_cmd_in[4*p +: 4] != 4'd0)) begin
          cap_busy[p] <= 1'b1;
          cap_cmd[p]  <= bus.req_cmd_in[4*p +: 4];
          cap_a[p]    <= bus.req_data_in[DATA_W*p +: DATA_W];
          cap_tag[p]  <= bus.req_tag_in[TAG_W*p +: TAG_W];
        end
      end
    end
  end

  // FIFO payload write with operand2 taken straight from the bus
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) begin
        mem_cmd[p][wr_ptr[p]] <= cap_cmd[p];
        mem_a[p][wr_ptr[p]]   <= cap_a[p];
        mem_b[p][wr_ptr[p]]   <= bus.req_data_in[DATA_W*p +: DATA_W];
        mem_tag[p][wr_ptr[p]] <= cap_tag[p];
      end
    end
  end

  // FIFO pointers, occupancy and arbitration priority
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      prio <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      if (gnt_valid)
        prio <= (gnt_port == PW'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p])
          wr_ptr[p] <= (wr_ptr[p] == AW'(DEPTH - 1)) ? '0 : wr_ptr[p] + 1'b1;
        if (pop[p])
          rd_ptr[p] <= (rd_ptr[p] == AW'(DEPTH - 1)) ? '0 : rd_ptr[p] + 1'b1;
        count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  // Register the granted FIFO head as the ALU operand stage
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_port  <= '0;
      s1_cmd   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= gnt_valid;
      s1_port  <= gnt_port;
      s1_cmd   <= mem_cmd[gnt_port][rd_ptr[gnt_port]];
      s1_a     <= mem_a[gnt_port][rd_ptr[gnt_port]];
      s1_b     <= mem_b[gnt_port][rd_ptr[gnt_port]];
      s1_tag   <= mem_tag[gnt_port][rd_ptr[gnt_port]];
    end
  end

  // ALU: error responses always carry zero data
  always_comb begin
    res_resp = 2'd0;
    res_data = '0;
    sum      = {1'b0, s1_a} + {1'b0, s1_b};
    if (s1_valid) begin
      res_resp = 2'd1;
      case (s1_cmd)
        4'd1: if (sum[DATA_W]) res_resp = 2'd2; else res_data = sum[DATA_W-1:0];
        4'd2: if (s1_b > s1_a) res_resp = 2'd2; else res_data = s1_a - s1_b;
        4'd5: res_data = s1_a << s1_b[SH_W-1:0];
        4'd6: res_data = s1_a >> s1_b[SH_W-1:0];
        default: res_resp = 2'd2;
      endcase
    end
  end

  // Steer the one-cycle result to its port; every other port shows idle
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      bus.out_resp <= '0;
      bus.out_data <= '0;
      bus.out_tag  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (s1_valid && (s1_port == PW'(p))) begin
          bus.out_resp[2*p +: 2]           <= res_resp;
          bus.out_data[DATA_W*p +: DATA_W] <= res_data;
          bus.out_tag[TAG_W*p +: TAG_W]    <= s1_tag;
        end else begin
          bus.out_resp[2*p +: 2]           <= 2'd0;
          bus.out_data[DATA_W*p +: DATA_W] <= '0;
          bus.out_tag[TAG_W*p +: TAG_W]    <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_calcn_engine.sv
// tb/tb_calcn_engine.sv - randomized scoreboard bench for calcn_engine
module tb_calcn_engine;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  logic c_clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t sbq [NP][$];

  bit          want    [NP];
  logic [3:0]  nxt_cmd [NP];
  logic [31:0] nxt_a   [NP];
  logic [31:0] nxt_b   [NP];
  logic [1:0]  nxt_tag [NP];
  int          nxt_lat [NP];
  bit          phase2  [NP];
  logic [3:0]  hold_cmd[NP];
  logic [31:0] hold_a  [NP];
  logic [31:0] hold_b  [NP];
  logic [1:0]  hold_tag[NP];
  int          hold_cyc[NP];
  bit          saw_busy[NP];
  logic [1:0]  tag_ctr [NP];

  calcn_engine_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

  calcn_engine #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(4)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] tag, input int ecyc);
    exp_t e;
    longint unsigned la, lb;
    la = a;
    lb = b;
    e.resp = 2'd1;
    e.data = 32'd0;
    e.tag  = tag;
    e.cyc  = ecyc;
    case (cmd)
      4'd1: if (la + lb > 64'hFFFF_FFFF) e.resp = 2'd2; else e.data = 32'(la + lb);
      4'd2: if (lb > la) e.resp = 2'd2; else e.data = 32'(la - lb);
      4'd5: e.data = 32'((la << (lb % 32)) & 64'hFFFF_FFFF);
      4'd6: e.data = 32'(la >> (lb % 32));
      default: e.resp = 2'd2;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    case ($urandom_range(0, 9))
      0, 1: return 4'd1;
      2, 3: return 4'd2;
      4, 5: return 4'd5;
      6, 7: return 4'd6;
      default: return 4'($urandom_range(3, 15));
    endcase
  endfunction

  // Monitor: pop and compare whenever a port presents a response
  always @(negedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [1:0]  t;
        exp_t e;
        r = bus.out_resp[2*p +: 2];
        d = bus.out_data[32*p +: 32];
        t = bus.out_tag[2*p +: 2];
        if (r != 2'd0) begin
          checks++;
          if (sbq[p].size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp port %0d cyc %0d got resp %0d data %h tag %0d, required none", p, cyc, r, d, t);
          end else begin
            e = sbq[p].pop_front();
            if (r != e.resp || d != e.data || t != e.tag || (e.cyc >= 0 && cyc != e.cyc)) begin
              errors++;
              $display("FAIL resp_match port %0d got resp %0d data %h tag %0d cyc %0d, required resp %0d data %h tag %0d cyc %0d",
                       p, r, d, t, cyc, e.resp, e.data, e.tag, e.cyc);
            end
          end
        end else begin
          checks++;
          if (d != 32'd0 || t != 2'd0) begin
            errors++;
            $display("FAIL idle_zero port %0d got data %h tag %0d, required 0 0", p, d, t);
          end
        end
      end
    end
  end

  task automatic step();
    for (int p = 0; p < NP; p++) begin
      if (phase2[p]) begin
        bus.req_data_in[32*p +: 32] = hold_b[p];
        bus.req_cmd_in[4*p +: 4]    = 4'($urandom_range(1, 15));
        bus.req_tag_in[2*p +: 2]    = 2'($urandom);
        sbq[p].push_back(model(hold_cmd[p], hold_a[p], hold_b[p], hold_tag[p], hold_cyc[p]));
        phase2[p] = 1'b0;
      end else if (want[p]) begin
        bus.req_cmd_in[4*p +: 4]    = nxt_cmd[p];
        bus.req_data_in[32*p +: 32] = nxt_a[p];
        bus.req_tag_in[2*p +: 2]    = nxt_tag[p];
        if (bus.req_ready[p]) begin
          phase2[p]   = 1'b1;
          hold_cmd[p] = nxt_cmd[p];
          hold_a[p]   = nxt_a[p];
          hold_b[p]   = nxt_b[p];
          hold_tag[p] = nxt_tag[p];
          hold_cyc[p] = (nxt_lat[p] >= 0) ? cyc + 4 + nxt_lat[p] : -1;
          tag_ctr[p]  = tag_ctr[p] + 2'd1;
        end else begin
          saw_busy[p] = 1'b1;
        end
      end else begin
        bus.req_cmd_in[4*p +: 4]    = 4'd0;
        bus.req_data_in[32*p +: 32] = $urandom;
        bus.req_tag_in[2*p +: 2]    = 2'($urandom);
      end
      want[p] = 1'b0;
    end
    @(negedge c_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] t, input int lat);
    want[p]    = 1'b1;
    nxt_cmd[p] = c;
    nxt_a[p]   = a;
    nxt_b[p]   = b;
    nxt_tag[p] = t;
    nxt_lat[p] = lat;
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (bus.out_resp != '0 || bus.out_data != '0 || bus.out_tag != '0 || bus.req_ready != '0) begin
      errors++;
      $display("FAIL %s got resp %h tag %h ready %h data_nz %0d, required all 0",
               name, bus.out_resp, bus.out_tag, bus.req_ready, bus.out_data != '0);
    end
  endtask

  task automatic do_reset(input string name);
    #2 reset = 1'b0;
    #1 check_reset_state(name);
    for (int p = 0; p < NP; p++) begin
      sbq[p].delete();
      phase2[p] = 1'b0;
      want[p]   = 1'b0;
    end
    bus.req_cmd_in = '0;
    @(negedge c_clk);
    @(negedge c_clk);
    #1 check_reset_state({name, "_hold"});
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready != 4'hF) begin
      errors++;
      $display("FAIL ready_after_reset got %h, required f", bus.req_ready);
    end
    @(negedge c_clk);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
    for (int p = 0; p < NP; p++) begin
      want[p] = 1'b0; phase2[p] = 1'b0; saw_busy[p] = 1'b0; tag_ctr[p] = 2'd0; nxt_lat[p] = -1;
    end
    repeat (3) @(negedge c_clk);
    #1 check_reset_state("reset_state");
    do_reset("reset_initial");

    set_req(0, 4'h2, 32'h158, 32'h12, 2'd1, 0); step(); idle(7);
    set_req(1, 4'h1, 32'h56, 32'h103, 2'd2, 0); step(); idle(7);
    set_req(2, 4'h2, 32'h18, 32'h32, 2'd3, 0); step(); idle(7);
    set_req(3, 4'h3, 32'h11, 32'h22, 2'd0, 0); step(); idle(7);
    set_req(0, 4'h1, 32'hFFFF_FFFF, 32'h1, 2'd2, 0); step(); idle(7);
    set_req(0, 4'h5, 32'h1, 32'h3F, 2'd3, 0); step(); idle(7);
    set_req(0, 4'h6, 32'h8000_0000, 32'd31, 2'd0, 0); step(); idle(7);

    do_reset("reset_before_burst");
    for (int p = 0; p < NP; p++) set_req(p, 4'h1, 32'h56, 32'h103, 2'(p), p);
    step(); idle(10);

    for (int p = 0; p < NP; p++) tag_ctr[p] = 2'd0;
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < NP; p++)
        if (!phase2[p]) set_req(p, rand_cmd(), rand_op(), rand_op(), tag_ctr[p], -1);
      step();
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (!saw_busy[p]) begin
        errors++;
        $display("FAIL ready_fall port %0d got never_busy, required busy seen", p);
      end
    end

    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 1) == 1)
          set_req(p, rand_cmd(), rand_op(), rand_op(), 2'($urandom), -1);
      step();
    end

    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < NP; p++) set_req(p, rand_cmd(), rand_op(), rand_op(), 2'($urandom), -1);
      step();
    end
    do_reset("reset_queued");
    idle(12);
    set_req(2, 4'h1, 32'h56, 32'h103, 2'd1, 0); step(); idle(8);

    idle(30);
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (sbq[p].size() != 0) begin
        errors++;
        $display("FAIL drain port %0d got %0d outstanding, required 0", p, sbq[p].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
